// File: rtl/cpu_boot_ctrl.sv
// Boot and run sequencer for the NanoCPU: streams a program image into memory
// with the CPU held in reset, then hands the memory port over and supervises the run.
module cpu_boot_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [CNT_W-1:0]  run_limit,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dataW,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_dataR,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_ce,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataR,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W:0]   words_loaded,
    output logic [CNT_W-1:0]  run_cycles
);

    // state   | meaning
    // IDLE    | CPU in reset, memory port idle, waiting for start
    // LOAD    | loader owns the memory port, accepting stream words
    // RELEASE | one-cycle gap; cpu_rst deasserts at the end of it
    // RUN     | CPU owns the memory port, run_cycles counting
    // HALT    | CPU back in reset, results held until next start
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t             r_state;
    logic               r_cpu_rst;
    logic [ADDR_W:0]    r_len;
    logic [CNT_W-1:0]   r_limit;
    logic [ADDR_W:0]    r_words;
    logic [CNT_W-1:0]   r_cycles;
    logic               r_timeout;

    logic [ADDR_W:0]    w_len_clamped;
    logic [ADDR_W:0]    w_words_next;
    logic               w_xfer;
    logic               w_budget_end;

    assign w_len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign w_words_next  = r_words + (ADDR_W+1)'(1);
    assign w_xfer        = (r_state == S_LOAD) && in_valid;
    // The CPU gets exactly run_limit cycles: leave on the last one.
    assign w_budget_end  = (r_limit != '0) && (r_cycles == r_limit - CNT_W'(1));

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cpu_rst <= 1'b1;
            r_len     <= '0;
            r_limit   <= '0;
            r_words   <= '0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    r_cpu_rst <= 1'b1;
                    if (start) begin
                        r_len     <= w_len_clamped;
                        r_limit   <= run_limit;
                        r_words   <= '0;
                        r_cycles  <= '0;
                        r_timeout <= 1'b0;
                        r_state   <= (w_len_clamped != '0) ? S_LOAD : S_RELEASE;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_words <= w_words_next;
                        if (w_words_next == r_len) begin
                            r_state <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    r_cpu_rst <= 1'b0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (r_cycles != '1) begin
                        r_cycles <= r_cycles + CNT_W'(1);
                    end
                    if (stop) begin
                        r_timeout <= 1'b0;
                        r_cpu_rst <= 1'b1;
                        r_state   <= S_HALT;
                    end else if (w_budget_end) begin
                        r_timeout <= 1'b1;
                        r_cpu_rst <= 1'b1;
                        r_state   <= S_HALT;
                    end
                end
                default: begin
                    r_cpu_rst <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_address = '0;
        mem_dataW   = '0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        if (w_xfer) begin
            mem_address = r_words[ADDR_W-1:0];
            mem_dataW   = in_data;
            mem_ce      = 1'b1;
            mem_we      = 1'b1;
        end else if (r_state == S_RUN) begin
            mem_address = cpu_address;
            mem_dataW   = cpu_dataW;
            mem_ce      = cpu_ce;
            mem_we      = cpu_we;
        end
    end

    assign cpu_dataR    = mem_dataR;
    assign cpu_rst      = r_cpu_rst;
    assign in_ready     = (r_state == S_LOAD);
    assign busy         = (r_state == S_LOAD) || (r_state == S_RELEASE) || (r_state == S_RUN);
    assign done         = (r_state == S_HALT);
    assign timeout      = r_timeout;
    assign words_loaded = r_words;
    assign run_cycles   = r_cycles;

endmodule
